// File: rtl/impix_pkg.sv
// Shared definitions for the image-pixelization block scheduler: CSR map,
// control/status bit positions, FSM state encoding and block-size limits.
package impix_pkg;

  localparam logic [2:0] CSR_CTRL        = 3'd0;
  localparam logic [2:0] CSR_STATUS      = 3'd1;
  localparam logic [2:0] CSR_SRC_BASE    = 3'd2;
  localparam logic [2:0] CSR_DST_BASE    = 3'd3;
  localparam logic [2:0] CSR_WIDTH       = 3'd4;
  localparam logic [2:0] CSR_HEIGHT      = 3'd5;
  localparam logic [2:0] CSR_BLK_LOG2    = 3'd6;
  localparam logic [2:0] CSR_BLOCK_COUNT = 3'd7;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_ABORT   = 2;

  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_DONE  = 1;
  localparam int STATUS_ERR   = 2;

  localparam logic [2:0] BLK_LOG2_MIN = 3'd1;
  localparam logic [2:0] BLK_LOG2_MAX = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WAIT_AVG = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DONE     = 3'd4
  } sched_state_e;

endpackage

// File: rtl/impix_block_sched_if.sv
// CSR bus and command stream of the block scheduler. The master modport is
// the scheduler's view; the slave modport is the bridge/datapath view.
interface impix_block_sched_if #(parameter int ADDR_W = 32);

  logic [2:0]        avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  // Command handshake: a command transfers on every cycle where cmd_valid and
  // cmd_ready are both high; once raised, cmd_valid and cmd_addr/write/last
  // stay unchanged until that transfer happens. cmd_ready may toggle freely.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic              cmd_last;

  modport master (
    input  avs_address, avs_write, avs_writedata, avs_read, cmd_ready,
    output avs_readdata, cmd_valid, cmd_addr, cmd_write, cmd_last
  );

  modport slave (
    output avs_address, avs_write, avs_writedata, avs_read, cmd_ready,
    input  avs_readdata, cmd_valid, cmd_addr, cmd_write, cmd_last
  );

endinterface

// File: rtl/impix_block_walker.sv
// Per-block pixel walker: raster-scans one clipped block and produces the byte
// address of the current pixel plus a flag marking the block's final pixel.
module impix_block_walker #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [3:0]        xmax,
  input  logic [3:0]        ymax,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] row_stride,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [3:0]        x_q;
  logic [3:0]        y_q;
  logic [3:0]        xmax_q;
  logic [3:0]        ymax_q;
  logic [ADDR_W-1:0] row_q;

  // row_q tracks the first pixel of the current block row so a row step is
  // one add of the image stride.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
      row_q  <= '0;
      addr   <= '0;
    end else if (load) begin
      x_q    <= '0;
      y_q    <= '0;
      xmax_q <= xmax;
      ymax_q <= ymax;
      row_q  <= base;
      addr   <= base;
    end else if (advance) begin
      if (x_q == xmax_q) begin
        x_q   <= '0;
        y_q   <= y_q + 4'd1;
        row_q <= row_q + row_stride;
        addr  <= row_q + row_stride;
      end else begin
        x_q  <= x_q + 4'd1;
        addr <= addr + ADDR_W'(4);
      end
    end
  end

  assign last = (x_q == xmax_q) && (y_q == ymax_q);

endmodule

// File: rtl/impix_block_sched.sv
// Block scheduler: CSR slave, block traversal FSM, block-origin tracking and
// edge clipping; per-pixel addressing is delegated to impix_block_walker.
module impix_block_sched
  import impix_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 12
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  impix_block_sched_if.master bus,
  input  logic                avg_valid,
  output logic                irq,
  output logic [3:0]          indicators_export,
  output sched_state_e        state_dbg
);

  sched_state_e      state;
  logic              irq_en_q, done_q, err_q, abort_pend;
  logic [31:0]       src_base, dst_base, rdata_q, csr_rdata;
  logic [DIM_W-1:0]  width, height, bx, by;
  logic [2:0]        blk_log2;
  logic [23:0]       block_count;
  logic              cmd_valid_q, cmd_write_q;
  logic [ADDR_W-1:0] blk_off, row_off;

  logic              busy, ctrl_wr, abort_req, start_req, cfg_ok, cmd_fire;
  logic              row_end, final_blk, walker_load, walker_adv, walker_last;
  logic [DIM_W:0]    blk_edge, nx_bx_wide, nx_by_wide, blk_w, blk_h;
  logic [DIM_W-1:0]  nx_bx, nx_by, ld_bx, ld_by, rem_w, rem_h;
  logic [ADDR_W-1:0] nx_row_off, nx_blk_off, ld_off, ld_base_sel, walker_addr;
  logic [ADDR_W-1:0] src_eff, dst_eff, row_stride;
  logic [3:0]        row_shamt, ld_xmax, ld_ymax;

  assign busy      = (state != ST_IDLE);
  assign ctrl_wr   = bus.avs_write && (bus.avs_address == CSR_CTRL);
  assign abort_req = ctrl_wr && bus.avs_writedata[CTRL_ABORT];
  assign start_req = ctrl_wr && bus.avs_writedata[CTRL_START] && !abort_req;
  assign cfg_ok    = (width != '0) && (height != '0) &&
                     (blk_log2 >= BLK_LOG2_MIN) && (blk_log2 <= BLK_LOG2_MAX);
  assign cmd_fire  = cmd_valid_q && bus.cmd_ready;

  assign src_eff    = ADDR_W'({src_base[31:2], 2'b00});
  assign dst_eff    = ADDR_W'({dst_base[31:2], 2'b00});
  assign row_stride = ADDR_W'({width, 2'b00});
  assign blk_edge   = (DIM_W+1)'(1) << blk_log2;
  assign row_shamt  = {1'b0, blk_log2} + 4'd2;

  // Origin of the block after the current one, one bit wider so the step past
  // a 4095-pixel edge cannot wrap.
  assign nx_bx_wide = {1'b0, bx} + blk_edge;
  assign nx_by_wide = {1'b0, by} + blk_edge;
  assign row_end    = (nx_bx_wide >= {1'b0, width});
  assign final_blk  = row_end && (nx_by_wide >= {1'b0, height});
  assign nx_bx      = row_end ? '0 : nx_bx_wide[DIM_W-1:0];
  assign nx_by      = row_end ? nx_by_wide[DIM_W-1:0] : by;
  assign nx_row_off = row_end ? row_off + (ADDR_W'(width) << row_shamt) : row_off;
  assign nx_blk_off = row_end ? nx_row_off : blk_off + (ADDR_W'(blk_edge) << 2);

  // Block loaded into the walker: first block on START, the same block for
  // the write phase, the next block when a write phase finishes.
  always_comb begin
    ld_bx       = bx;
    ld_by       = by;
    ld_off      = blk_off;
    ld_base_sel = src_eff;
    case (state)
      ST_IDLE: begin
        ld_bx  = '0;
        ld_by  = '0;
        ld_off = '0;
      end
      ST_WAIT_AVG: ld_base_sel = dst_eff;
      ST_WRITE: begin
        ld_bx  = nx_bx;
        ld_by  = nx_by;
        ld_off = nx_blk_off;
      end
      default: ;
    endcase
  end

  assign rem_w   = width - ld_bx;
  assign rem_h   = height - ld_by;
  assign blk_w   = ({1'b0, rem_w} < blk_edge) ? {1'b0, rem_w} : blk_edge;
  assign blk_h   = ({1'b0, rem_h} < blk_edge) ? {1'b0, rem_h} : blk_edge;
  assign ld_xmax = blk_w[3:0] - 4'd1;
  assign ld_ymax = blk_h[3:0] - 4'd1;

  assign walker_load = (state == ST_IDLE && start_req && cfg_ok) ||
                       (state == ST_WAIT_AVG && avg_valid && !abort_req) ||
                       (state == ST_WRITE && cmd_fire && walker_last && !final_blk &&
                        !abort_req && !abort_pend);
  assign walker_adv  = cmd_fire && !walker_last;

  impix_block_walker #(.ADDR_W(ADDR_W)) u_walker (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .load       (walker_load),
    .advance    (walker_adv),
    .xmax       (ld_xmax),
    .ymax       (ld_ymax),
    .base       (ld_base_sel + ld_off),
    .row_stride (row_stride),
    .addr       (walker_addr),
    .last       (walker_last)
  );

  always_comb begin
    csr_rdata = '0;
    case (bus.avs_address)
      CSR_CTRL:        csr_rdata[CTRL_IRQ_EN] = irq_en_q;
      CSR_STATUS:      csr_rdata = {29'b0, err_q, done_q, busy};
      CSR_SRC_BASE:    csr_rdata = src_base;
      CSR_DST_BASE:    csr_rdata = dst_base;
      CSR_WIDTH:       csr_rdata = 32'(width);
      CSR_HEIGHT:      csr_rdata = 32'(height);
      CSR_BLK_LOG2:    csr_rdata = 32'(blk_log2);
      CSR_BLOCK_COUNT: csr_rdata = 32'(block_count);
      default:         csr_rdata = '0;
    endcase
  end

  // CSR writes come first so that FSM-driven status updates later in the
  // block take precedence (a DONE set beats a same-cycle W1C).
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state       <= ST_IDLE;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      abort_pend  <= 1'b0;
      src_base    <= '0;
      dst_base    <= '0;
      width       <= '0;
      height      <= '0;
      blk_log2    <= '0;
      block_count <= '0;
      rdata_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      bx          <= '0;
      by          <= '0;
      blk_off     <= '0;
      row_off     <= '0;
    end else begin
      if (bus.avs_write) begin
        case (bus.avs_address)
          CSR_CTRL:     irq_en_q <= bus.avs_writedata[CTRL_IRQ_EN];
          CSR_STATUS: begin
            if (bus.avs_writedata[STATUS_DONE]) done_q <= 1'b0;
            if (bus.avs_writedata[STATUS_ERR])  err_q  <= 1'b0;
          end
          CSR_SRC_BASE: src_base <= bus.avs_writedata;
          CSR_DST_BASE: dst_base <= bus.avs_writedata;
          CSR_WIDTH:    width    <= bus.avs_writedata[DIM_W-1:0];
          CSR_HEIGHT:   height   <= bus.avs_writedata[DIM_W-1:0];
          CSR_BLK_LOG2: blk_log2 <= bus.avs_writedata[2:0];
          default: ;
        endcase
      end
      if (bus.avs_read) rdata_q <= csr_rdata;
      if (cmd_fire && cmd_write_q && walker_last) block_count <= block_count + 24'd1;

      case (state)
        ST_IDLE: begin
          if (start_req) begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            block_count <= '0;
            if (!cfg_ok) begin
              err_q <= 1'b1;
            end else begin
              state       <= ST_READ;
              cmd_valid_q <= 1'b1;
              cmd_write_q <= 1'b0;
              bx          <= '0;
              by          <= '0;
              blk_off     <= '0;
              row_off     <= '0;
            end
          end
        end
        ST_READ, ST_WRITE: begin
          if (abort_req || abort_pend) begin
            // A stalled command must still complete before the abort lands.
            if (cmd_valid_q && !bus.cmd_ready) begin
              abort_pend <= 1'b1;
            end else begin
              abort_pend  <= 1'b0;
              cmd_valid_q <= 1'b0;
              err_q       <= 1'b1;
              state       <= ST_IDLE;
            end
          end else if (cmd_fire && walker_last) begin
            if (state == ST_READ) begin
              cmd_valid_q <= 1'b0;
              state       <= ST_WAIT_AVG;
            end else if (final_blk) begin
              cmd_valid_q <= 1'b0;
              state       <= ST_DONE;
            end else begin
              cmd_write_q <= 1'b0;
              bx          <= nx_bx;
              by          <= nx_by;
              blk_off     <= nx_blk_off;
              row_off     <= nx_row_off;
              state       <= ST_READ;
            end
          end
        end
        ST_WAIT_AVG: begin
          if (abort_req) begin
            err_q <= 1'b1;
            state <= ST_IDLE;
          end else if (avg_valid) begin
            cmd_valid_q <= 1'b1;
            cmd_write_q <= 1'b1;
            state       <= ST_WRITE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.avs_readdata   = rdata_q;
  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.cmd_addr       = walker_addr;
  assign bus.cmd_write      = cmd_write_q;
  assign bus.cmd_last       = walker_last && cmd_valid_q;
  assign irq                = done_q && irq_en_q;
  assign indicators_export  = {1'b0, err_q, done_q, busy};
  assign state_dbg          = state;

endmodule
